move_sequencer: RTL and testbench
=================================

# move_sequencer

Command-driven motion controller that sequences the two wheel drives against cumulative odometry from `dual_wheel_interface`. It accepts one move command at a time (forward, backward, turn left, turn right) through a valid/ready handshake and captures the odometry baseline at start. It enables and steers each motor until that wheel has covered the target distance, then stops, settles and reports completion with a status code. It sits between the high-level navigation logic and the motor driver pins.

## Interface

- `TIMEOUT_CYCLES`, 50_000_000: maximum RUN duration in clocks (1 s at 50 MHz).
- `SETTLE_CYCLES`, 1000: motor-off dwell before completion is reported; must be ≥1.

- `clk`  input  1  system clock, 50 MHz.
- `reset`  input  1  asynchronous, active-low (0 = reset).
- `cmd_valid`  input  1  command present.
- `cmd_ready`  output  1  block can accept a command.
- `cmd_type`  input  2  00 forward, 01 backward, 10 turn left, 11 turn right.
- `cmd_target`  input  32  per-wheel travel target, mm, unsigned.
- `abort`  input  1  stop current move.
- `distance_pulse_left`, `distance_pulse_right`  input  32 each  cumulative wheel distance, mm, modulo 2^32.
- `motor_left_en`, `motor_right_en`  output  1 each  motor enables.
- `motor_left_dir`, `motor_right_dir`  output  1 each  1 = wheel forward.
- `busy`  output  1  move in progress.
- `done`  output  1  one-cycle completion pulse.
- `status`  output  2  00 ok, 01 timeout, 10 aborted; valid when `done`=1, held until next accept.
- `progress`  output  32  (|dl|+|dr|)>>1, mm.

## Operation

- All outputs are registered. Reset values: `cmd_ready`=0, all motor outputs 0, `busy`=0, `done`=0, `status`=00, `progress`=0; state IDLE, timers 0.
- States: IDLE, CAPTURE, RUN, SETTLE, DONE.
- IDLE: `cmd_ready`=1. On `cmd_valid`&`cmd_ready`, latch type and target, clear `status` and `progress`, and go to CAPTURE. `abort` is ignored.
- CAPTURE (1 cycle): latch `base_l`/`base_r` from the distance inputs and clear the timer.
  - `abort` → SETTLE, status 10.
  - `cmd_target`=0 → SETTLE, status 00; motors are never enabled.
  - Otherwise → RUN.
- RUN: wheel deltas are dl = cur_l − base_l and dr = cur_r − base_r, mod 2^32, interpreted as signed. The magnitude |d| is used, so reverse motion counts and counter wrap is harmless.
  - A wheel is "reached" when its |d| ≥ target.
  - Each wheel is enabled only while not reached; each wheel stops independently.
  - Directions: forward L=1 R=1; backward L=0 R=0; turn left L=0 R=1; turn right L=1 R=0.
  - `progress` updates every RUN cycle.
  - Exit conditions, with same-cycle priority abort > both-reached > timeout:
    - abort → SETTLE, status 10.
    - Both wheels reached → SETTLE, status 00.
    - Timer = TIMEOUT_CYCLES−1 → SETTLE, status 01.
- SETTLE: motors off. Count SETTLE_CYCLES cycles, then go to DONE. `abort` is ignored.
- DONE (1 cycle): `done`=1, then → IDLE.
- `busy`=1 in CAPTURE, RUN, SETTLE and DONE.
- `progress` and `status` hold their values after DONE until the next command is accepted.
- Reset asserted mid-move: all outputs take their reset values immediately (asynchronously), including motor enables.

## Timing

- Accept at edge E0. After E0: `cmd_ready`=0, `busy`=1.
- E1: baseline latched. Motor enables are high after E1.
- A wheel reaching target sampled at edge Ek: that wheel's enable is low after Ek (1-cycle latency from input to motor-off).
- Both reached at Ek: SETTLE from Ek. `done` is high for the single cycle after edge Ek+SETTLE_CYCLES.
- `cmd_ready`=1 one cycle after `done`. Minimum command-to-command spacing is SETTLE_CYCLES+3 cycles.
- Timeout: RUN lasts exactly TIMEOUT_CYCLES cycles.
- Abort in RUN: motors off one cycle after `abort` is sampled.

## Test plan

- Forward, target 1256, both wheels stepping +628 every 20 cycles → enables drop 1 cycle after the second step; `done` with status 00; `progress`=1256; dirs 1/1.
- Turn right, target 628; left stepping +628, right stepping −628 (mod 2^32) → dirs L=1 R=0; both stop; status 00; `progress`=628.
- Unequal wheels: left reaches 1256 at cycle 40, right at cycle 100 → `motor_left_en` low from cycle 41 while `motor_right_en` stays high until cycle 101; one `done`.
- Wrap: baseline 0xFFFF_FD8C, target 1256, left/right advance +628 twice (crossing 0) → reached correctly; status 00.
- Timeout: TIMEOUT_CYCLES=200, inputs frozen → RUN lasts 200 cycles; status 01; motors off.
- Abort at RUN cycle 5 with simultaneous both-reached → status 10. Separately: reset pulled low mid-RUN → all outputs 0 immediately; after release, `cmd_ready`=1 on the first edge.

Source files
------------

// File: rtl/move_sequencer.sv
// move_sequencer: runs one wheel move per command, stopping each motor once its odometry delta covers the target
module move_sequencer #(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int SETTLE_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [31:0] cmd_target,
  input  logic        abort,
  input  logic [31:0] distance_pulse_left,
  input  logic [31:0] distance_pulse_right,
  output logic        motor_left_en,
  output logic        motor_right_en,
  output logic        motor_left_dir,
  output logic        motor_right_dir,
  output logic        busy,
  output logic        done,
  output logic [1:0]  status,
  output logic [31:0] progress
);
  localparam int TMAX = TIMEOUT_CYCLES > SETTLE_CYCLES ? TIMEOUT_CYCLES : SETTLE_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  typedef enum logic [2:0] {IDLE, CAPTURE, RUN, SETTLE, DONE} state_t;
  state_t state, state_nx;
  logic [1:0] typ, status_nx;
  logic [31:0] tgt, base_l, base_r, dl, dr, mag_l, mag_r, prog_nx;
  logic [TW-1:0] timer, timer_nx;
  logic accept, reach_l, reach_r;
  assign accept = cmd_valid & cmd_ready;
  assign dl = distance_pulse_left - base_l;
  assign dr = distance_pulse_right - base_r;
  // signed deltas taken by magnitude so reverse travel and counter wrap both count
  assign mag_l = dl[31] ? -dl : dl;
  assign mag_r = dr[31] ? -dr : dr;
  assign reach_l = state == RUN && mag_l >= tgt;
  assign reach_r = state == RUN && mag_r >= tgt;
  assign prog_nx = 32'(({1'b0, mag_l} + {1'b0, mag_r}) >> 1);
  always_comb begin
    state_nx = state;
    status_nx = status;
    case (state)
      IDLE: begin
        state_nx = accept ? CAPTURE : IDLE;
        status_nx = accept ? 2'b00 : status;
      end
      CAPTURE: begin
        state_nx = abort || tgt == '0 ? SETTLE : RUN;
        status_nx = abort ? 2'b10 : 2'b00;
      end
      RUN: begin
        state_nx = abort || (reach_l && reach_r) || timer == TW'(TIMEOUT_CYCLES - 1) ? SETTLE : RUN;
        status_nx = abort ? 2'b10 : reach_l && reach_r ? 2'b00 :
                    timer == TW'(TIMEOUT_CYCLES - 1) ? 2'b01 : status;
      end
      SETTLE: state_nx = timer == TW'(SETTLE_CYCLES - 1) ? DONE : SETTLE;
      default: state_nx = IDLE;
    endcase
    timer_nx = state_nx != state || state == IDLE || state == DONE ? '0 : timer + 1'b1;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      timer <= '0;
      typ <= '0;
      tgt <= '0;
      base_l <= '0;
      base_r <= '0;
      cmd_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      status <= 2'b00;
      progress <= '0;
      motor_left_en <= 1'b0;
      motor_right_en <= 1'b0;
      motor_left_dir <= 1'b0;
      motor_right_dir <= 1'b0;
    end else begin
      state <= state_nx;
      timer <= timer_nx;
      status <= status_nx;
      cmd_ready <= state_nx == IDLE;
      busy <= state_nx != IDLE;
      done <= state_nx == DONE;
      motor_left_en <= state_nx == RUN && !reach_l;
      motor_right_en <= state_nx == RUN && !reach_r;
      motor_left_dir <= state_nx == RUN && (typ == 2'b00 || typ == 2'b11);
      motor_right_dir <= state_nx == RUN && (typ == 2'b00 || typ == 2'b10);
      typ <= accept ? cmd_type : typ;
      tgt <= accept ? cmd_target : tgt;
      base_l <= state == CAPTURE ? distance_pulse_left : base_l;
      base_r <= state == CAPTURE ? distance_pulse_right : base_r;
      progress <= accept ? '0 : state == RUN ? prog_nx : progress;
    end
endmodule

// File: tb/tb_move_sequencer.sv
// tb_move_sequencer: directed moves checked every cycle against a behavioural model plus literal expectations
module tb_move_sequencer;
  localparam int T = 200;
  localparam int S = 3;
  logic clk = 0, reset = 0, cmd_valid = 0, abort = 0;
  logic [1:0] cmd_type = 0;
  logic [31:0] cmd_target = 0, left = 32'd1000, right = 32'd2000;
  logic cmd_ready, motor_left_en, motor_right_en, motor_left_dir, motor_right_dir, busy, done;
  logic [1:0] status;
  logic [31:0] progress;
  int checks = 0, errors = 0, len_hi = 0, ren_hi = 0, done_cnt = 0;

  move_sequencer #(.TIMEOUT_CYCLES(T), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_type(cmd_type), .cmd_target(cmd_target), .abort(abort),
    .distance_pulse_left(left), .distance_pulse_right(right),
    .motor_left_en(motor_left_en), .motor_right_en(motor_right_en),
    .motor_left_dir(motor_left_dir), .motor_right_dir(motor_right_dir),
    .busy(busy), .done(done), .status(status), .progress(progress));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint mag(input logic [31:0] d);
    longint v = longint'($signed(d));
    return v < 0 ? -v : v;
  endfunction

  // model: phase 0 idle, 1 capture, 2 run, 3 settle, 4 done; outputs derived from the phase after each edge
  int ph = 0, tcount = 0, scount = 0;
  logic [1:0] mtype = 0, m_status = 0;
  logic [31:0] mtgt = 0, mbl = 0, mbr = 0, m_prog = 0;
  logic m_ready = 0, m_busy = 0, m_done = 0, m_len = 0, m_ren = 0, m_ldir = 0, m_rdir = 0;
  longint al, ar;
  bit rl, rr;
  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      ph = 0; tcount = 0; scount = 0; m_status = 0; m_prog = 0;
      {m_ready, m_busy, m_done, m_len, m_ren, m_ldir, m_rdir} = '0;
    end else begin
      rl = 0; rr = 0;
      case (ph)
        0: if (cmd_valid && m_ready) begin
          mtype = cmd_type; mtgt = cmd_target; m_status = 0; m_prog = 0; ph = 1;
        end
        1: begin
          mbl = left; mbr = right; tcount = 0; scount = 0;
          if (abort) begin ph = 3; m_status = 2; end
          else if (mtgt == 0) begin ph = 3; m_status = 0; end
          else ph = 2;
        end
        2: begin
          al = mag(left - mbl);
          ar = mag(right - mbr);
          rl = al >= longint'(mtgt);
          rr = ar >= longint'(mtgt);
          m_prog = 32'((al + ar) / 2);
          tcount++;
          if (abort) begin ph = 3; m_status = 2; end
          else if (rl && rr) begin ph = 3; m_status = 0; end
          else if (tcount == T) begin ph = 3; m_status = 1; end
        end
        3: begin scount++; if (scount == S) ph = 4; end
        default: ph = 0;
      endcase
      m_ready = ph == 0;
      m_busy = ph != 0;
      m_done = ph == 4;
      m_len = ph == 2 && !rl;
      m_ren = ph == 2 && !rr;
      m_ldir = ph == 2 && (mtype == 0 || mtype == 3);
      m_rdir = ph == 2 && (mtype == 0 || mtype == 2);
    end
  end

  always @(negedge clk) begin
    chk("cmd_ready", cmd_ready, m_ready);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    chk("status", status, m_status);
    chk("progress", progress, m_prog);
    chk("left_en", motor_left_en, m_len);
    chk("right_en", motor_right_en, m_ren);
    chk("left_dir", motor_left_dir, m_ldir);
    chk("right_dir", motor_right_dir, m_rdir);
    if (motor_left_en) len_hi++;
    if (motor_right_en) ren_hi++;
    if (done) done_cnt++;
  end

  task automatic start(input logic [1:0] t, input logic [31:0] tg);
    int n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    chk("ready_wait", cmd_ready, 1);
    cmd_type = t; cmd_target = tg; cmd_valid = 1;
    @(negedge clk);
    cmd_valid = 0; len_hi = 0; ren_hi = 0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (!done && n < 2000) begin @(negedge clk); n++; end
    chk(nm, done, 1);
    @(negedge clk);
  endtask

  task automatic step(input int n, input logic [31:0] dl, input logic [31:0] dr);
    repeat (n) @(negedge clk);
    left = left + dl; right = right + dr;
  endtask

  int d0;
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    reset = 1;
    @(negedge clk);
    chk("first_ready", cmd_ready, 1);
    // forward, two equal steps
    start(2'b00, 1256);
    repeat (5) @(negedge clk);
    chk("fwd_ldir", motor_left_dir, 1);
    chk("fwd_rdir", motor_right_dir, 1);
    step(15, 628, 628);
    step(20, 628, 628);
    wait_done("fwd_done");
    chk("fwd_status", status, 0);
    chk("fwd_prog", progress, 1256);
    chk("fwd_len", len_hi, 40);
    chk("fwd_ren", ren_hi, 40);
    // turn right, opposite wheel motion
    start(2'b11, 628);
    repeat (5) @(negedge clk);
    chk("tr_ldir", motor_left_dir, 1);
    chk("tr_rdir", motor_right_dir, 0);
    step(5, 628, -32'd628);
    wait_done("tr_done");
    chk("tr_status", status, 0);
    chk("tr_prog", progress, 628);
    chk("tr_len", len_hi, 10);
    // unequal wheels, independent stop
    d0 = done_cnt;
    start(2'b00, 1256);
    step(40, 1256, 0);
    step(60, 0, 1256);
    wait_done("uneq_done");
    chk("uneq_len", len_hi, 40);
    chk("uneq_ren", ren_hi, 100);
    chk("uneq_dones", done_cnt - d0, 1);
    chk("uneq_prog", progress, 1256);
    // counter wrap across zero
    left = 32'hFFFF_FD8C; right = 32'hFFFF_FD8C;
    start(2'b00, 1256);
    step(10, 628, 628);
    step(10, 628, 628);
    wait_done("wrap_done");
    chk("wrap_status", status, 0);
    chk("wrap_prog", progress, 1256);
    chk("wrap_len", len_hi, 20);
    // timeout with frozen odometry
    start(2'b01, 1000);
    wait_done("to_done");
    chk("to_status", status, 1);
    chk("to_len", len_hi, T);
    chk("to_ren", ren_hi, T);
    // abort beats a simultaneous both-reached
    start(2'b10, 500);
    repeat (5) @(negedge clk);
    abort = 1; left = left + 500; right = right + 500;
    @(negedge clk);
    abort = 0;
    wait_done("ab_done");
    chk("ab_status", status, 2);
    chk("ab_prog", progress, 500);
    chk("ab_len", len_hi, 5);
    // zero target never enables motors
    start(2'b00, 0);
    wait_done("z_done");
    chk("z_status", status, 0);
    chk("z_len", len_hi + ren_hi, 0);
    // abort during capture
    start(2'b00, 100);
    abort = 1;
    @(negedge clk);
    abort = 0;
    wait_done("cab_done");
    chk("cab_status", status, 2);
    chk("cab_len", len_hi, 0);
    // reset mid-run
    start(2'b00, 5000);
    step(5, 100, 0);
    repeat (4) @(negedge clk);
    chk("mr_prog", progress, 50);
    chk("mr_len", motor_left_en, 1);
    #1 reset = 0;
    #1;
    chk("mr_rst_en", {motor_left_en, motor_right_en, motor_left_dir, motor_right_dir}, 0);
    chk("mr_rst_flags", {cmd_ready, busy, done, status}, 0);
    chk("mr_rst_prog", progress, 0);
    @(negedge clk);
    reset = 1;
    @(negedge clk);
    chk("mr_ready", cmd_ready, 1);
    chk("mr_busy", busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
